// File: rtl/tessia_hazard_if.sv
// Pipeline-control bundle between the Tessia datapath and its hazard unit.
// The datapath is the master; the hazard unit is the slave.
interface tessia_hazard_if #(
  parameter int unsigned RaW  = 4,
  parameter int unsigned CntW = 16
);
  logic [RaW-1:0]  ra1_d, ra2_d, ra1_e, ra2_e;
  logic [RaW-1:0]  wa3_e, wa3_m, wa3_w;
  logic            regwrite_e, regwrite_m, regwrite_w;
  logic            memtoreg_e;
  logic            pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w;
  logic            branch_taken_e;
  logic            mem_req_m, mem_ready_m;
  logic [1:0]      forward_ae, forward_be;
  logic            stall_f, stall_d, stall_e, stall_m;
  logic            flush_d, flush_e, flush_w;
  logic            mem_err;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  modport master (
    output ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w,
    output regwrite_e, regwrite_m, regwrite_w, memtoreg_e,
    output pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e,
    output mem_req_m, mem_ready_m,
    input  forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w,
    input  regwrite_e, regwrite_m, regwrite_w, memtoreg_e,
    input  pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e,
    input  mem_req_m, mem_ready_m,
    output forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/tessia_hazard_ctrl.sv
// Tessia five-stage hazard unit: E-stage forwarding, load-use stall, PC-write flush,
// multi-cycle data-memory freeze with timeout fault, and saturating stall/flush counters.
module tessia_hazard_ctrl #(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic           clk,
  input logic           reset,
  tessia_hazard_if.slave hz
);
  localparam int unsigned RaW   = $clog2(NREGS);
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMwait, StErr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [RaW-1:0] ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic           ldr_stall, pc_pend, mem_wait, freeze;
  logic [1:0]     forward_ae, forward_be;
  logic           stall_f, stall_d, stall_e, stall_m;
  logic           flush_d, flush_e, flush_w, mem_err;

  assign ra1_d = hz.ra1_d;
  assign ra2_d = hz.ra2_d;
  assign ra1_e = hz.ra1_e;
  assign ra2_e = hz.ra2_e;
  assign wa3_e = hz.wa3_e;
  assign wa3_m = hz.wa3_m;
  assign wa3_w = hz.wa3_w;

  // M-stage result is newer than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [RaW-1:0] ra, input logic [RaW-1:0] wa_m,
                                         input logic we_m, input logic [RaW-1:0] wa_w,
                                         input logic we_w);
    if (we_m && (wa_m == ra)) begin
      return 2'b10;
    end else if (we_w && (wa_w == ra)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign ldr_stall = hz.memtoreg_e && hz.regwrite_e && ((ra1_d == wa3_e) || (ra2_d == wa3_e));
  assign pc_pend   = hz.pcsrc_d || hz.pcsrc_e || hz.pcsrc_m;
  assign mem_wait  = hz.mem_req_m && !hz.mem_ready_m;
  assign freeze    = mem_wait || (state_q == StErr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The counter holds the number of not-ready cycles seen so far, so the cycle that
  // enters MWAIT already counts as one; it reads zero whenever the FSM is in RUN.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      StRun: begin
        if (mem_wait) begin
          state_d    = StMwait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StMwait: begin
        if (hz.mem_ready_m) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    forward_ae = fwd_sel(ra1_e, wa3_m, hz.regwrite_m, wa3_w, hz.regwrite_w);
    forward_be = fwd_sel(ra2_e, wa3_m, hz.regwrite_m, wa3_w, hz.regwrite_w);
    mem_err    = (state_q == StErr);
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    if (freeze) begin
      // Hold everything up to M and let a bubble drain into W.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = ldr_stall || pc_pend;
      stall_d = ldr_stall;
      flush_d = pc_pend || hz.pcsrc_w || hz.branch_taken_e;
      flush_e = ldr_stall || hz.branch_taken_e;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((flush_d || flush_e) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.forward_ae = forward_ae;
  assign hz.forward_be = forward_be;
  assign hz.stall_f    = stall_f;
  assign hz.stall_d    = stall_d;
  assign hz.stall_e    = stall_e;
  assign hz.stall_m    = stall_m;
  assign hz.flush_d    = flush_d;
  assign hz.flush_e    = flush_e;
  assign hz.flush_w    = flush_w;
  assign hz.mem_err    = mem_err;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_tessia_hazard_ctrl.sv
// Directed bench for tessia_hazard_ctrl: two instances (16-bit and 2-bit counters,
// both with a 4-cycle memory timeout) driven in lockstep, checked through a scoreboard.
module tb_tessia_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e;
  logic       pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, mem_req_m, mem_ready_m;

  tessia_hazard_if #(.RaW(4), .CntW(16)) if_a ();
  tessia_hazard_if #(.RaW(4), .CntW(2))  if_b ();

  tessia_hazard_ctrl #(.NREGS(16), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .hz(if_a.slave));
  tessia_hazard_ctrl #(.NREGS(16), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .hz(if_b.slave));

  assign if_a.ra1_d = ra1_d;                  assign if_b.ra1_d = ra1_d;
  assign if_a.ra2_d = ra2_d;                  assign if_b.ra2_d = ra2_d;
  assign if_a.ra1_e = ra1_e;                  assign if_b.ra1_e = ra1_e;
  assign if_a.ra2_e = ra2_e;                  assign if_b.ra2_e = ra2_e;
  assign if_a.wa3_e = wa3_e;                  assign if_b.wa3_e = wa3_e;
  assign if_a.wa3_m = wa3_m;                  assign if_b.wa3_m = wa3_m;
  assign if_a.wa3_w = wa3_w;                  assign if_b.wa3_w = wa3_w;
  assign if_a.regwrite_e = regwrite_e;        assign if_b.regwrite_e = regwrite_e;
  assign if_a.regwrite_m = regwrite_m;        assign if_b.regwrite_m = regwrite_m;
  assign if_a.regwrite_w = regwrite_w;        assign if_b.regwrite_w = regwrite_w;
  assign if_a.memtoreg_e = memtoreg_e;        assign if_b.memtoreg_e = memtoreg_e;
  assign if_a.pcsrc_d = pcsrc_d;              assign if_b.pcsrc_d = pcsrc_d;
  assign if_a.pcsrc_e = pcsrc_e;              assign if_b.pcsrc_e = pcsrc_e;
  assign if_a.pcsrc_m = pcsrc_m;              assign if_b.pcsrc_m = pcsrc_m;
  assign if_a.pcsrc_w = pcsrc_w;              assign if_b.pcsrc_w = pcsrc_w;
  assign if_a.branch_taken_e = branch_taken_e; assign if_b.branch_taken_e = branch_taken_e;
  assign if_a.mem_req_m = mem_req_m;          assign if_b.mem_req_m = mem_req_m;
  assign if_a.mem_ready_m = mem_ready_m;      assign if_b.mem_ready_m = mem_ready_m;

  typedef struct {
    string       tag;
    logic [43:0] vec_a;  // {fa, fb, stall f/d/e/m, flush d/e/w, mem_err, stall_cnt, flush_cnt}
    logic [1:0]  sc_b;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sc = '0;
  logic [15:0] exp_fc = '0;
  logic [1:0]  exp_sc_b = '0;

  task automatic clear_inputs();
    {ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w} = '0;
    {regwrite_e, regwrite_m, regwrite_w, memtoreg_e} = '0;
    {pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, mem_req_m, mem_ready_m} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_sc   = '0;
    exp_fc   = '0;
    exp_sc_b = '0;
  endtask

  task automatic check_front();
    exp_t        e;
    logic [43:0] obs;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      return;
    end
    e   = sb.pop_front();
    obs = {if_a.forward_ae, if_a.forward_be, if_a.stall_f, if_a.stall_d, if_a.stall_e,
           if_a.stall_m, if_a.flush_d, if_a.flush_e, if_a.flush_w, if_a.mem_err,
           if_a.stall_cnt, if_a.flush_cnt};
    checks++;
    assert (obs === e.vec_a) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.vec_a);
    end
    checks++;
    assert (if_b.stall_cnt === e.sc_b) else begin
      errors++;
      $error("FAIL %s_sat_cnt: observed %0d expected %0d", e.tag, if_b.stall_cnt, e.sc_b);
    end
  endtask

  // Inputs are already driven; stl = {f,d,e,m}, fl = {d,e,w}.
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] stl, input logic [2:0] fl, input logic err);
    exp_t e;
    e.tag   = tag;
    e.vec_a = {fa, fb, stl, fl, err, exp_sc, exp_fc};
    e.sc_b  = exp_sc_b;
    sb.push_back(e);
    @(negedge clk);
    check_front();
    if (stl[3]) begin
      if (exp_sc != 16'hffff) exp_sc = exp_sc + 16'd1;
      if (exp_sc_b != 2'd3) exp_sc_b = exp_sc_b + 2'd1;
    end
    if ((fl[2] || fl[1]) && (exp_fc != 16'hffff)) exp_fc = exp_fc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    step("reset_state", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    regwrite_m = 1; wa3_m = 3; ra1_e = 3; regwrite_w = 1; wa3_w = 3; ra2_e = 3;
    step("fwd_m_priority", 2'b10, 2'b10, 4'b0000, 3'b000, 1'b0);
    regwrite_m = 0;
    step("fwd_w", 2'b01, 2'b01, 4'b0000, 3'b000, 1'b0);
    regwrite_m = 1; wa3_m = 2; ra1_e = 2;
    step("fwd_mixed", 2'b10, 2'b01, 4'b0000, 3'b000, 1'b0);
    regwrite_m = 0; regwrite_w = 0;
    step("fwd_none", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    clear_inputs();
    memtoreg_e = 1; regwrite_e = 1; wa3_e = 5; ra2_d = 5;
    step("load_use", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
    regwrite_e = 0;
    step("load_no_write", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    clear_inputs();
    step("after_load_use", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    pcsrc_d = 1;
    step("pcsrc_d", 2'b00, 2'b00, 4'b1000, 3'b100, 1'b0);
    pcsrc_d = 0; pcsrc_e = 1;
    step("pcsrc_e", 2'b00, 2'b00, 4'b1000, 3'b100, 1'b0);
    pcsrc_e = 0; pcsrc_m = 1;
    step("pcsrc_m", 2'b00, 2'b00, 4'b1000, 3'b100, 1'b0);
    pcsrc_m = 0; pcsrc_w = 1;
    step("pcsrc_w", 2'b00, 2'b00, 4'b0000, 3'b100, 1'b0);
    clear_inputs();
    step("after_branch", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    memtoreg_e = 1; regwrite_e = 1; wa3_e = 7; ra1_d = 7; branch_taken_e = 1;
    step("load_use_and_taken", 2'b00, 2'b00, 4'b1100, 3'b110, 1'b0);

    // Three not-ready cycles, ready on the fourth: the ready lands on the timeout cycle.
    clear_inputs();
    mem_req_m = 1; branch_taken_e = 1; pcsrc_d = 1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("mem_wait_%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    end
    pcsrc_d = 0; mem_ready_m = 1;
    step("mem_ready", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
    clear_inputs();
    step("after_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    mem_req_m = 1;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("timeout_%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, (i >= 4) ? 1'b1 : 1'b0);
    end
    mem_req_m = 0; branch_taken_e = 1;
    step("err_sticky", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1);
    do_reset();
    step("post_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    memtoreg_e = 1; regwrite_e = 1; wa3_e = 9; ra1_d = 9;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("saturate_%0d", i), 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
    end
    clear_inputs();
    step("after_saturate", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    checks++;
    assert (if_b.stall_cnt === 2'd3) else begin
      errors++;
      $error("FAIL sat_hold: observed %0d expected 3", if_b.stall_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tessia_hazard_ctrl.md
# tessia_hazard_ctrl

Parametrised hazard and pipeline-control unit for the five-stage Tessia core: the successor to the fixed 16-register, single-cycle-memory hazard unit. It generates the Execute-stage forwarding selects and the load-use stall. It adds three things the previous unit lacked:

- full branch/PC-write flush control;
- stall-on-wait support for a multi-cycle data memory with a req/ready handshake and timeout detection;
- saturating stall/flush performance counters.

It sits beside the datapath and drives the enables and clears of the F/D, D/E, E/M and M/W pipeline registers.

## Interface

Parameters:

- NREGS, 16: architectural register count; RA_W = $clog2(NREGS).
- MEM_TIMEOUT, 64: number of consecutive not-ready memory cycles that constitutes a fault; must be at least 2.
- CNT_W, 16: width of the performance counters.

Ports (clock and reset first):

- clk, in, 1: the single clock of the block.
- reset, in, 1: reset is synchronous and active-low.
- ra1_d, ra2_d, in, RA_W each: Decode-stage source registers.
- ra1_e, ra2_e, in, RA_W each: Execute-stage source registers.
- wa3_e, wa3_m, wa3_w, in, RA_W each: destination registers in E, M and W.
- regwrite_e, regwrite_m, regwrite_w, in, 1 each: destination write valid in E, M and W.
- memtoreg_e, in, 1: the instruction in E is a load.
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, in, 1 each: the instruction in that stage writes the PC.
- branch_taken_e, in, 1: a branch resolved taken in E.
- mem_req_m, in, 1: the M stage is accessing data memory.
- mem_ready_m, in, 1: data memory has completed the access.
- forward_ae, forward_be, out, 2 each: operand A/B select. 00 = register file, 01 = ResultW, 10 = ALUOutM.
- stall_f, stall_d, stall_e, stall_m, out, 1 each: hold the named pipeline register (active-high).
- flush_d, flush_e, flush_w, out, 1 each: clear the named pipeline register to a bubble.
- mem_err, out, 1: sticky memory-timeout fault.
- stall_cnt, flush_cnt, out, CNT_W each: saturating event counters.

## Operation

Forwarding (combinational):

- forward_ae = 10 if regwrite_m && wa3_m==ra1_e.
- Otherwise forward_ae = 01 if regwrite_w && wa3_w==ra1_e.
- Otherwise forward_ae = 00.
- M has priority over W. forward_be follows the same rules with ra2_e.

Derived terms:

- ldr_stall = memtoreg_e && regwrite_e && (ra1_d==wa3_e || ra2_d==wa3_e).
- pc_pend = pcsrc_d || pcsrc_e || pcsrc_m.
- mem_wait = mem_req_m && !mem_ready_m.

FSM states:

- RUN: normal operation.
- RUN to MWAIT: on mem_wait.
- MWAIT to RUN: when mem_ready_m is seen.
- MWAIT to ERR: when the wait counter reaches MEM_TIMEOUT-1 and mem_ready_m is still low.
- ERR: left only by reset.
- freeze = mem_wait || state==ERR.

Outputs in the frozen condition (freeze=1):

- stall_f, stall_d, stall_e and stall_m are all 1.
- flush_w = 1, so a bubble enters W.
- flush_d and flush_e are forced to 0; a frozen stage is never cleared.

Outputs in the unfrozen condition (freeze=0):

- stall_f = ldr_stall || pc_pend.
- stall_d = ldr_stall.
- stall_e = stall_m = flush_w = 0.
- flush_d = pc_pend || pcsrc_w || branch_taken_e.
- flush_e = ldr_stall || branch_taken_e.

Wait counter:

- Width is $clog2(MEM_TIMEOUT).
- Cleared in RUN; increments each MWAIT cycle.
- In ERR, mem_err = 1; all other outputs follow the frozen condition.

Performance counters:

- stall_cnt increments on each cycle where stall_f=1.
- flush_cnt increments on each cycle where flush_d || flush_e.
- Both saturate at 2^CNT_W-1 and do not wrap.

## Timing

- Forward, stall and flush outputs are combinational from the current-cycle inputs and state, with zero latency. The freeze in the first not-ready cycle is therefore immediate, through mem_wait, before the FSM has registered MWAIT.
- State, the wait counter, mem_err and both counters update on the rising clk edge.
- Reset (reset=0 at an edge) returns:
  - state to RUN;
  - the wait counter, stall_cnt and flush_cnt to 0;
  - mem_err to 0.

  With all data inputs at 0, every output reads 0 after reset. Reset during MWAIT or ERR behaves identically.
- If mem_ready_m rises on the cycle where the counter equals MEM_TIMEOUT-1, the access completes: the next state is RUN, not ERR.
- When ldr_stall and branch_taken_e are both 1, flush_e=1, flush_d=1 and stall_d=1. The flush takes priority at the D/E register; the datapath treats flush as overriding the enable.
- When a register is written in both M and W, forwarding uses the M value (10).
- Register index NREGS-1 is not special-cased here. PC-register reads are handled in decode.

## Test plan

- RAW forwarding:
  - Set regwrite_m=1, wa3_m=3, ra1_e=3, regwrite_w=1, wa3_w=3, ra2_e=3. Require forward_ae=10, forward_be=10.
  - Then drop regwrite_m. Require forward_ae=01, forward_be=01.
- Load-use: set memtoreg_e=1, regwrite_e=1, wa3_e=5, ra2_d=5 for one cycle. Require stall_f=1, stall_d=1, flush_e=1, flush_d=0; stall_cnt becomes 1 after the edge.
- Branch: pulse pcsrc_d, then pcsrc_e, then pcsrc_m, then pcsrc_w on consecutive cycles. Require stall_f=1 for the first three cycles, flush_d=1 for all four, and flush_cnt=4.
- Memory wait: hold mem_req_m=1 and mem_ready_m=0 for 3 cycles, then set mem_ready_m=1.
  - Require all stall_* outputs and flush_w =1 from the first wait cycle.
  - Require flush_d=flush_e=0 even with branch_taken_e=1.
  - Require a return to normal outputs on the ready cycle, with mem_err=0.
- Timeout: with MEM_TIMEOUT=4, hold not-ready for 6 cycles.
  - Require mem_err=1 from the edge after the 4th wait cycle, with freeze held.
  - Assert reset=0 for one edge; require mem_err=0, all outputs 0 and both counters 0.
- Saturation: with CNT_W=2, hold ldr_stall for 5 cycles. Require stall_cnt to stop at 3.
